demux_vc_param: RTL and testbench
=================================

// Module: demux_vc_param
// PURPOSE
//  Parametrised virtual-channel demultiplexer between the input FIFO pop stage and the per-VC FIFOs.
//  Routes each accepted word to one of NUM_VC outputs using the word's top bits as the VC id.
//  Adds per-VC backpressure through a one-entry hold register, upstream ready, and out-of-range VC detection.
// PARAMETERS
//  DATA_WIDTH  6  word width; VC id occupies the top VC_SEL_W bits
//  NUM_VC      2  number of virtual channels, >=2
//  CNT_WIDTH   8  width of each per-VC push counter (VC_COUNT_EN only)
//  (local) VC_SEL_W = $clog2(NUM_VC); vc_id = data_in[DATA_WIDTH-1 -: VC_SEL_W]
// PORTS
//  clk          in   1                     clock, all logic on posedge
//  reset        in   1                     asynchronous, active-low reset
//  data_in      in   DATA_WIDTH            word from upstream pop stage
//  valid_in     in   1                     data_in valid this cycle
//  ready_out    out  1                     demux can accept; combinational = !hold_valid
//  vc_full      in   NUM_VC                per-VC almost-full from downstream FIFOs, bit i = VC i
//  data_out     out  NUM_VC*DATA_WIDTH     slice i = word for VC i, zero when push[i]=0
//  push         out  NUM_VC                one-hot push strobe, at most one bit set
//  err_vc       out  1                     sticky: an out-of-range VC id was seen
//  push_count   out  NUM_VC*CNT_WIDTH      slice i = pushes issued to VC i (VC_COUNT_EN)
// BEHAVIOUR
//  - Reset (reset=0, async): data_out=0, push=0, err_vc=0, hold_valid=0, hold_data=0, push_count=0.
//  - Accept: the word transfers on a clock edge when valid_in=1 and ready_out=1. valid_in with ready_out=0 is ignored.
//    Upstream holds data_in/valid_in stable until the transfer occurs.
//  - Two states: PASS (hold_valid=0) and HOLD (hold_valid=1).
//  - PASS, accepted word, vc_id<NUM_VC, vc_full[vc_id]=0: next edge push[vc_id]=1.
//    data_out slice vc_id = word; all other slices=0. Latency 1 cycle.
//  - PASS, accepted word, vc_full[vc_id]=1: word stored in hold register.
//    Next edge push=0, data_out=0, move to HOLD; ready_out drops.
//  - HOLD: each edge re-test vc_full[hold vc].
//    If 0: push hold word (same output rules), hold_valid=0, back to PASS.
//    No new word accepted in this cycle (ready_out=0).
//  - Any vc_id>=NUM_VC (possible only if NUM_VC not power of 2): word accepted and dropped.
//    No push; err_vc set at next edge, stays 1 until reset.
//  - No accept and no hold release: push=0 and data_out=0 next edge (strobes are single-cycle).
//  - vc_full only blocks its own VC at the moment of issue; words are never reordered
//    (one word in flight max).
//  - Reset asserted mid-HOLD: held word discarded; everything returns to reset values immediately.
// CONFIGURATION
//  VC_COUNT_EN defined: push_count slice i increments on every cycle push[i]=1.
//    Saturates at all-ones, no wrap; cleared only by reset.
//  VC_COUNT_EN undefined: no counter logic; push_count tied to 0; port list unchanged.
// TESTING
//  1 defaults, vc_full=0, data_in=6'b100101 valid 1 cycle -> next cycle push=2'b10,
//    data_out[11:6]=6'h25, data_out[5:0]=0, ready_out=1
//  2 vc_full=2'b01, send 6'h0A -> push=0, ready_out=0;
//    drop vc_full[0] after 3 cycles -> next edge push=2'b01, data_out[5:0]=6'h0A, ready_out=1
//  3 vc_full=2'b01 with HOLD on VC0, send VC1 word 6'h31 -> not accepted until VC0 released,
//    then 6'h31 pushed on VC1 after the VC0 word
//  4 NUM_VC=3, DATA_WIDTH=8, data_in=8'hC5 (vc_id=3) -> no push, err_vc=1 sticky;
//    later 8'h45 -> push=3'b010
//  5 reset pulled low during HOLD -> push=0, ready_out=1, err_vc=0 asynchronously;
//    held word never pushed
//  6 VC_COUNT_EN, CNT_WIDTH=2, 5 words to VC0 -> push_count[1:0]=2'b11 (saturated),
//    VC1 count=0

Source files
------------

// File: rtl/demux_vc_param.sv
// demux_vc_param: virtual-channel demultiplexer sitting between the input
// FIFO pop stage and the per-VC FIFOs. The top VC_SEL_W bits of each word
// select the VC. A blocked VC parks the word in a one-entry hold register,
// and upstream stalls until that word drains. Ids >= NUM_VC are dropped and
// raise a sticky err_vc.
// Optional: define VC_COUNT_EN to build saturating per-VC push counters;
// otherwise push_count is tied to zero.

// Per-VC output lane: registered push strobe and data slice, plus the
// optional push counter.
module demux_vc_lane #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]  count
);

  // single-cycle strobe; the data slice is zero whenever it is not pushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push <= 1'b0;
      data <= '0;
    end else begin
      push <= sel;
      data <= sel ? word : '0;
    end
  end

`ifdef VC_COUNT_EN
  // count registered pushes, stick at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   count <= '0;
    else if (push && count != '1) count <= count + CNT_WIDTH'(1);
  end
`else
  assign count = '0;
`endif

endmodule

module demux_vc_param #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_VC     = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  input  logic [NUM_VC-1:0]              vc_full,
  output logic [NUM_VC*DATA_WIDTH-1:0]   data_out,
  output logic [NUM_VC-1:0]              push,
  output logic                           err_vc,
  output logic [NUM_VC*CNT_WIDTH-1:0]    push_count
);

  localparam int VC_SEL_W = $clog2(NUM_VC);

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
  } hold_t;

  hold_t                  hold;
  logic [VC_SEL_W-1:0]    vc_id, hold_vc;
  logic [NUM_VC-1:0]      in_hit, hold_hit, issue_sel;
  logic                   accept, in_range, full_in, full_hold;
  logic                   release_hold, direct, park;
  logic [DATA_WIDTH-1:0]  issue_word;

  assign vc_id   = data_in[DATA_WIDTH-1 -: VC_SEL_W];
  assign hold_vc = hold.data[DATA_WIDTH-1 -: VC_SEL_W];

  // One-hot decode of both ids. An out-of-range id decodes to all zeros,
  // so it never indexes vc_full past NUM_VC.
  for (genvar g = 0; g < NUM_VC; g++) begin : g_dec
    assign in_hit[g]   = (vc_id   == VC_SEL_W'(g));
    assign hold_hit[g] = (hold_vc == VC_SEL_W'(g));
  end

  assign in_range  = |in_hit;
  assign full_in   = |(in_hit & vc_full);
  assign full_hold = |(hold_hit & vc_full);

  // A held word blocks all new input, which keeps ordering strict.
  assign ready_out    = !hold.vld;
  assign accept       = valid_in && ready_out;
  assign release_hold = hold.vld && !full_hold;
  assign direct       = accept && in_range && !full_in;
  assign park         = accept && in_range && full_in;

  assign issue_sel  = release_hold ? hold_hit : (direct ? in_hit : '0);
  assign issue_word = release_hold ? hold.data : data_in;

  // hold register: park on a blocked VC, drain when that VC frees up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (release_hold) begin
      hold.vld <= 1'b0;
    end else if (park) begin
      hold.vld  <= 1'b1;
      hold.data <= data_in;
    end
  end

  // sticky flag for words whose id has no matching VC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    err_vc <= 1'b0;
    else if (accept && !in_range)  err_vc <= 1'b1;
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_lane
    demux_vc_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .sel   (issue_sel[g]),
      .word  (issue_word),
      .push  (push[g]),
      .data  (data_out[g*DATA_WIDTH +: DATA_WIDTH]),
      .count (push_count[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_vc_param.sv
// Scoreboard bench for demux_vc_param. Instance A uses 6-bit words, 2 VCs,
// and 2-bit counters. Instance B uses 8-bit words and 3 VCs, so it can
// exercise out-of-range ids.
module tb_demux_vc_param;

  typedef struct {
    logic [7:0]  push;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [5:0]  data_in_a;
  logic        valid_a, ready_a, err_a;
  logic [1:0]  vc_full_a, push_a;
  logic [11:0] data_out_a;
  logic [3:0]  count_a;

  logic [7:0]  data_in_b;
  logic        valid_b, ready_b, err_b;
  logic [2:0]  vc_full_b, push_b;
  logic [23:0] data_out_b;
  logic [23:0] count_b;

  demux_vc_param #(.DATA_WIDTH(6), .NUM_VC(2), .CNT_WIDTH(2)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in_a), .valid_in(valid_a),
    .ready_out(ready_a), .vc_full(vc_full_a), .data_out(data_out_a),
    .push(push_a), .err_vc(err_a), .push_count(count_a)
  );

  demux_vc_param #(.DATA_WIDTH(8), .NUM_VC(3), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in_b), .valid_in(valid_b),
    .ready_out(ready_b), .vc_full(vc_full_b), .data_out(data_out_b),
    .push(push_b), .err_vc(err_b), .push_count(count_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   cnt_exp[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // queue an expected push on A; saturating 2-bit count model
  task automatic expa(input logic [1:0] p, input logic [11:0] d);
    qa.push_back('{push: 8'(p), data: 32'(d)});
    for (int i = 0; i < 2; i++)
      if (p[i] && cnt_exp[i] < 3) cnt_exp[i]++;
  endtask

  task automatic expb(input logic [2:0] p, input logic [23:0] d);
    qb.push_back('{push: 8'(p), data: 32'(d)});
  endtask

  // monitor A: every push must match the next queued word, idle data is zero
  always @(negedge clk) begin
    if (reset) begin
      if (push_a != '0) begin
        if (qa.size() == 0) chk("a_unexpected_push", 32'(push_a), 32'h0);
        else begin
          ea = qa.pop_front();
          chk("a_push", 32'(push_a), ea.push);
          chk("a_data", 32'(data_out_a), ea.data);
        end
      end else chk("a_idle_data", 32'(data_out_a), 32'h0);
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (reset) begin
      if (push_b != '0) begin
        if (qb.size() == 0) chk("b_unexpected_push", 32'(push_b), 32'h0);
        else begin
          eb = qb.pop_front();
          chk("b_push", 32'(push_b), eb.push);
          chk("b_data", 32'(data_out_b), eb.data);
        end
      end else chk("b_idle_data", 32'(data_out_b), 32'h0);
    end
  end

  initial begin
    reset = 1'b0;
    data_in_a = '0; valid_a = 1'b0; vc_full_a = '0;
    data_in_b = '0; valid_b = 1'b0; vc_full_b = '0;
    cnt_exp = '{0, 0};
    #12;
    chk("rst_push", 32'(push_a), 32'h0);
    chk("rst_data", 32'(data_out_a), 32'h0);
    chk("rst_ready", 32'(ready_a), 32'h1);
    chk("rst_err", 32'(err_b), 32'h0);
    chk("rst_count", 32'(count_a), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: direct push on VC1
    data_in_a = 6'b100101; valid_a = 1'b1;
    expa(2'b10, {6'h25, 6'h00});
    tick();
    valid_a = 1'b0;
    chk("t1_ready", 32'(ready_a), 32'h1);
    tick();

    // 2: VC0 full, word parks, drains when VC0 frees
    vc_full_a = 2'b01; data_in_a = 6'h0A; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_ready", 32'(ready_a), 32'h0);
      tick();
    end
    expa(2'b01, {6'h00, 6'h0A});
    vc_full_a = 2'b00;
    tick();
    chk("t2_release_ready", 32'(ready_a), 32'h1);
    tick();

    // 3: VC1 word waits behind held VC0 word
    vc_full_a = 2'b01; data_in_a = 6'h0A; valid_a = 1'b1;
    tick();
    data_in_a = 6'h31;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_ready", 32'(ready_a), 32'h0);
      tick();
    end
    expa(2'b01, {6'h00, 6'h0A});
    expa(2'b10, {6'h31, 6'h00});
    vc_full_a = 2'b00;
    tick();
    chk("t3_ready", 32'(ready_a), 32'h1);
    tick();
    valid_a = 1'b0;
    tick();
    tick();

    // 4: out-of-range id on 3-VC instance
    data_in_b = 8'hC5; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    chk("t4_err_set", 32'(err_b), 32'h1);
    chk("t4_ready", 32'(ready_b), 32'h1);
    tick();
    tick();
    chk("t4_err_sticky", 32'(err_b), 32'h1);
    data_in_b = 8'h45; valid_b = 1'b1;
    expb(3'b010, {8'h00, 8'h45, 8'h00});
    tick();
    valid_b = 1'b0;
    tick();
    chk("t4_err_still", 32'(err_b), 32'h1);

    // 5: async reset while holding
    vc_full_a = 2'b01; data_in_a = 6'h0A; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    chk("t5_pre_ready", 32'(ready_a), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_push", 32'(push_a), 32'h0);
    chk("t5_ready", 32'(ready_a), 32'h1);
    chk("t5_err", 32'(err_b), 32'h0);
    chk("t5_count", 32'(count_a), 32'h0);
    cnt_exp = '{0, 0};
    vc_full_a = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // 6: five VC0 words back-to-back
    for (int k = 1; k <= 5; k++) begin
      data_in_a = 6'(k); valid_a = 1'b1;
      expa(2'b01, {6'h00, 6'(k)});
      tick();
    end
    valid_a = 1'b0;
    for (int i = 0; i < 3; i++) tick();
`ifdef VC_COUNT_EN
    chk("t6_cnt_vc0", 32'(count_a[1:0]), 32'(cnt_exp[0]));
    chk("t6_cnt_vc1", 32'(count_a[3:2]), 32'(cnt_exp[1]));
`else
    chk("t6_cnt_vc0", 32'(count_a[1:0]), 32'h0);
    chk("t6_cnt_vc1", 32'(count_a[3:2]), 32'h0);
`endif
    chk("t6_cnt_b", count_b[23:0], 32'h0);

    chk("qa_drained", 32'(qa.size()), 32'h0);
    chk("qb_drained", 32'(qb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
